level_sensor_filter: RTL and testbench
======================================

Name: level_sensor_filter

Overview:
- Parametrised successor to the liquid-level sensor front end.
- Takes an N-wide thermometer-coded float-switch bus and synchronises, debounces and validates it.
- Converts valid codes to a count and a rounded percentage, and holds the last good level on faults.
- Reports transient and sticky input errors with a fault counter to the display/alarm logic downstream.

Parameters:
- N_SENSORS, 8, number of level switches; 2..32.
- STABLE_CYCLES, 1000, consecutive identical synchronised samples required before a code is accepted; >=2.
- ERR_CNT_W, 8, width of saturating fault counter.

Ports:
- clk_100MHz  in  1  system clock
- reset  in  1  async active-high reset
- sensors_input  in  N_SENSORS  raw switch bus, bit 0 = lowest switch, asynchronous to clock
- err_clear  in  1  sync pulse; clears error_sticky and error_count
- level_count  out  $clog2(N_SENSORS+1)  number of wetted switches, last accepted
- level_pct  out  7  level in percent, 0..100
- level_valid  out  1  high once any valid code has been accepted since reset
- level_update  out  1  one-cycle pulse when level_count changes
- input_error  out  1  high while the current stable code is not a thermometer code
- error_sticky  out  1  set on any accepted invalid code; held until err_clear
- error_count  out  ERR_CNT_W  saturating count of entries into FAULT

Behaviour:
- Reset is asynchronous, active-high, clock clk_100MHz. All outputs are 0 during reset. Synchroniser flops, debounce counter and state also clear. State = SETTLING.
- Synchroniser: two flops on sensors_input give s2.
- Debounce: p holds the previous s2.
  - If s2 != p, the counter is set to 0.
  - Otherwise the counter increments, saturating at STABLE_CYCLES-1.
  - A code is "stable" on the cycle the counter equals STABLE_CYCLES-1.
  - Latency from a settled change at the pin to updated outputs is STABLE_CYCLES+2 clock edges.
- Code validity: the code is valid iff it equals (1<<k)-1 for k in 0..N_SENSORS. All-zero is valid (k=0); all-ones is valid (k=N).
- Percentage: level_pct = (k*100 + N/2)/N, integer, rounding half-up. Generate it as a constant table at elaboration; no runtime divider.
  - N=8 gives 0,13,25,38,50,63,75,88,100.
- FSM states:
  - SETTLING: waiting for stability. Outputs hold their last values.
  - OK: the last accepted code is valid.
  - FAULT: the last accepted code is invalid.
- Transitions. Evaluate only on a stable cycle; any s2 change returns the FSM to SETTLING without altering outputs.
  - Stable valid code:
    - level_count<=k, level_pct<=table[k], level_valid<=1, input_error<=0; state -> OK.
    - level_update=1 for one cycle iff k differs from the previous level_count, or level_valid was 0.
  - Stable invalid code:
    - input_error<=1, error_sticky<=1.
    - level_count and level_pct hold their last good values; level_valid is unchanged.
    - error_count increments (saturating) only on entry to FAULT from any state other than FAULT.
    - state -> FAULT.
- A stable code is processed once. The counter stays saturated, so the FSM re-evaluates each cycle, but outputs are idempotent. level_update must not repeat, and error_count must not re-increment.
- err_clear: clears error_sticky and error_count next edge. If err_clear coincides with a new FAULT entry, the clear wins for error_count (result 0), and error_sticky ends 1. input_error is not affected by err_clear.
- Reset mid-debounce discards the pending sample. After release, the first acceptance needs STABLE_CYCLES+2 edges.

Test Plan:
- N=8, STABLE_CYCLES=4. After reset, drive 8'h00 and hold.
  - Required: level_valid=1, level_count=0, level_pct=0 and one level_update pulse at edge 6.
  - All outputs are 0 before edge 6.
- Step 8'h00 -> 8'h0F -> 8'hFF, each held 10 cycles.
  - Required: level_pct 50 then 100, level_count 4 then 8, exactly one level_update per step, each 6 edges after the change.
- Hold 8'h07, then toggle bit 3 every 2 cycles for 20 cycles, then settle at 8'h07.
  - Required: no level_update, level_pct stays 38 throughout.
- From 8'h07, apply 8'h05 for 10 cycles, then 8'h07.
  - Required: input_error=1, error_sticky=1, error_count=1, level_pct held at 38 during the fault.
  - Then input_error=0 and error_sticky still 1. There is no level_update on return, because k is unchanged.
- Two separate faults (8'h05, then 8'h0B) separated by a valid code, then an err_clear pulse.
  - Required: error_count=2 before the clear, then error_sticky=0 and error_count=0.
- Assert reset with 8'h03 pending 2 cycles into debounce.
  - Required: all outputs 0 immediately (asynchronous).
  - After release, level_count=2 and level_pct=25 at the 6th edge.

Source files
------------

// File: rtl/level_sensor_filter.sv
// Float-switch front end: synchronises and debounces a thermometer-coded level bus,
// validates it, and publishes count/percentage with transient and sticky fault reporting.
module level_sensor_filter #(
    parameter int N_SENSORS     = 8,
    parameter int STABLE_CYCLES = 1000,
    parameter int ERR_CNT_W     = 8
) (
    input  logic                           clk_100MHz,
    input  logic                           reset,
    input  logic [N_SENSORS-1:0]           sensors_input,
    input  logic                           err_clear,
    output logic [$clog2(N_SENSORS+1)-1:0] level_count,
    output logic [6:0]                     level_pct,
    output logic                           level_valid,
    output logic                           level_update,
    output logic                           input_error,
    output logic                           error_sticky,
    output logic [ERR_CNT_W-1:0]           error_count
);

    localparam int CW = $clog2(N_SENSORS + 1);
    localparam int DW = $clog2(STABLE_CYCLES);
    localparam logic [DW-1:0] CNT_MAX = DW'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_SETTLING = 2'd0,
        ST_OK       = 2'd1,
        ST_FAULT    = 2'd2
    } state_e;

    logic [N_SENSORS-1:0] sync1_q, sync2_q, prev_q;
    logic [2:0]           warm_q;
    logic [DW-1:0]        cnt_q, cnt_d;
    state_e               state_q, state_d;

    logic [CW-1:0]        level_count_q, level_count_d;
    logic [6:0]           level_pct_q, level_pct_d;
    logic                 level_valid_q, level_valid_d;
    logic                 level_update_q, level_update_d;
    logic                 input_error_q, input_error_d;
    logic                 error_sticky_q, error_sticky_d;
    logic [ERR_CNT_W-1:0] error_count_q, error_count_d;

    logic [CW-1:0]        ones_s;
    logic [N_SENSORS:0]   code_ext_s;
    logic                 is_therm_s;
    logic                 stable_s;
    logic [6:0]           pct_tbl [0:N_SENSORS];

    // Percentage lookup built from constants at elaboration, rounding half-up.
    for (genvar g = 0; g <= N_SENSORS; g++) begin : g_pct
        assign pct_tbl[g] = 7'((g * 100 + N_SENSORS / 2) / N_SENSORS);
    end

    // Popcount and thermometer check: code+1 must be a power of two.
    always_comb begin
        ones_s = '0;
        for (int i = 0; i < N_SENSORS; i++) begin
            ones_s = ones_s + CW'(sync2_q[i]);
        end
        code_ext_s = {1'b0, sync2_q};
        is_therm_s = ((code_ext_s + (N_SENSORS + 1)'(1)) & code_ext_s) == '0;
    end

    // Debounce counter; warm_q keeps the count at zero until prev_q holds a real post-reset sample.
    always_comb begin
        if (!warm_q[2] || (sync2_q != prev_q)) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + DW'(1);
        end
        stable_s = (cnt_d == CNT_MAX);
    end

    // Next-state and output logic; every stable cycle re-evaluates but results are idempotent.
    always_comb begin
        state_d        = state_q;
        level_count_d  = level_count_q;
        level_pct_d    = level_pct_q;
        level_valid_d  = level_valid_q;
        level_update_d = 1'b0;
        input_error_d  = input_error_q;
        error_sticky_d = error_sticky_q;
        error_count_d  = error_count_q;

        if (!stable_s) begin
            state_d = ST_SETTLING;
        end else if (is_therm_s) begin
            state_d        = ST_OK;
            level_count_d  = ones_s;
            level_pct_d    = pct_tbl[ones_s];
            level_valid_d  = 1'b1;
            input_error_d  = 1'b0;
            level_update_d = (ones_s != level_count_q) || !level_valid_q;
        end else begin
            state_d        = ST_FAULT;
            input_error_d  = 1'b1;
            error_sticky_d = 1'b1;
            if ((state_q != ST_FAULT) && (error_count_q != {ERR_CNT_W{1'b1}})) begin
                error_count_d = error_count_q + ERR_CNT_W'(1);
            end else begin
                error_count_d = error_count_q;
            end
        end

        // A coincident new fault keeps the sticky flag set but the count still clears.
        if (err_clear) begin
            error_count_d = '0;
            if (!(stable_s && !is_therm_s)) begin
                error_sticky_d = 1'b0;
            end else begin
                error_sticky_d = 1'b1;
            end
        end else begin
            error_count_d = error_count_d;
        end
    end

    // State, synchroniser, debounce and output registers.
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            sync1_q        <= '0;
            sync2_q        <= '0;
            prev_q         <= '0;
            warm_q         <= 3'b000;
            cnt_q          <= '0;
            state_q        <= ST_SETTLING;
            level_count_q  <= '0;
            level_pct_q    <= 7'd0;
            level_valid_q  <= 1'b0;
            level_update_q <= 1'b0;
            input_error_q  <= 1'b0;
            error_sticky_q <= 1'b0;
            error_count_q  <= '0;
        end else begin
            sync1_q        <= sensors_input;
            sync2_q        <= sync1_q;
            prev_q         <= sync2_q;
            warm_q         <= {warm_q[1:0], 1'b1};
            cnt_q          <= cnt_d;
            state_q        <= state_d;
            level_count_q  <= level_count_d;
            level_pct_q    <= level_pct_d;
            level_valid_q  <= level_valid_d;
            level_update_q <= level_update_d;
            input_error_q  <= input_error_d;
            error_sticky_q <= error_sticky_d;
            error_count_q  <= error_count_d;
        end
    end

    assign level_count  = level_count_q;
    assign level_pct    = level_pct_q;
    assign level_valid  = level_valid_q;
    assign level_update = level_update_q;
    assign input_error  = input_error_q;
    assign error_sticky = error_sticky_q;
    assign error_count  = error_count_q;

endmodule

// File: tb/tb_level_sensor_filter.sv
// Directed bench for level_sensor_filter with N=8, STABLE_CYCLES=4 (acceptance 6 edges after a change).
module tb_level_sensor_filter;

    logic       clk_100MHz;
    logic       reset;
    logic [7:0] sensors_input;
    logic       err_clear;
    logic [3:0] level_count;
    logic [6:0] level_pct;
    logic       level_valid;
    logic       level_update;
    logic       input_error;
    logic       error_sticky;
    logic [7:0] error_count;

    int n_checks;
    int n_errors;

    level_sensor_filter #(
        .N_SENSORS(8),
        .STABLE_CYCLES(4),
        .ERR_CNT_W(8)
    ) dut (
        .clk_100MHz(clk_100MHz),
        .reset(reset),
        .sensors_input(sensors_input),
        .err_clear(err_clear),
        .level_count(level_count),
        .level_pct(level_pct),
        .level_valid(level_valid),
        .level_update(level_update),
        .input_error(input_error),
        .error_sticky(error_sticky),
        .error_count(error_count)
    );

    initial clk_100MHz = 1'b0;
    always #5 clk_100MHz = ~clk_100MHz;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_100MHz);
        #1;
    endtask

    function automatic logic all_zero();
        return (level_count == 4'd0) && (level_pct == 7'd0) && !level_valid && !level_update
            && !input_error && !error_sticky && (error_count == 8'd0);
    endfunction

    // Drive code, hold for cycles; count update pulses, first pulse tick, ticks where pct != watch_pct.
    task automatic hold(input logic [7:0] code, input int cycles, input int watch_pct,
                        output int ups, output int first_up, output int pct_dev);
        ups = 0;
        first_up = 0;
        pct_dev = 0;
        sensors_input = code;
        for (int i = 1; i <= cycles; i++) begin
            tick();
            if (level_update) begin
                ups++;
                if (first_up == 0) first_up = i;
            end
            if ((watch_pct >= 0) && (int'(level_pct) != watch_pct)) pct_dev++;
        end
    endtask

    initial begin
        int ups, first_up, pct_dev, tot_ups, tot_dev;
        logic zero_ok;
        n_checks = 0;
        n_errors = 0;
        reset = 1'b1;
        sensors_input = 8'h00;
        err_clear = 1'b0;

        #3;
        chk("reset_outputs_zero", all_zero(), 1'b1);
        tick();
        tick();
        reset = 1'b0;

        // First acceptance of 0x00 after reset
        zero_ok = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            if (!all_zero()) zero_ok = 1'b0;
        end
        chk("pre_accept_zero", zero_ok, 1'b1);
        tick();
        chk("first_valid", level_valid, 1'b1);
        chk("first_count", level_count, 4'd0);
        chk("first_pct", level_pct, 7'd0);
        chk("first_update", level_update, 1'b1);
        hold(8'h00, 4, 0, ups, first_up, pct_dev);
        chk("first_update_once", ups, 0);

        // Level steps
        hold(8'h0F, 10, -1, ups, first_up, pct_dev);
        chk("step4_ups", ups, 1);
        chk("step4_latency", first_up, 6);
        chk("step4_count", level_count, 4'd4);
        chk("step4_pct", level_pct, 7'd50);
        hold(8'hFF, 10, -1, ups, first_up, pct_dev);
        chk("step8_ups", ups, 1);
        chk("step8_latency", first_up, 6);
        chk("step8_count", level_count, 4'd8);
        chk("step8_pct", level_pct, 7'd100);
        hold(8'h07, 10, -1, ups, first_up, pct_dev);
        chk("step3_ups", ups, 1);
        chk("step3_latency", first_up, 6);
        chk("step3_pct", level_pct, 7'd38);

        // Bounce on bit 3 must never be accepted
        tot_ups = 0;
        tot_dev = 0;
        for (int j = 0; j < 10; j++) begin
            hold(((j % 2) == 0) ? 8'h0F : 8'h07, 2, 38, ups, first_up, pct_dev);
            tot_ups += ups;
            tot_dev += pct_dev;
        end
        hold(8'h07, 10, 38, ups, first_up, pct_dev);
        tot_ups += ups;
        tot_dev += pct_dev;
        chk("bounce_no_update", tot_ups, 0);
        chk("bounce_pct_held", tot_dev, 0);

        // Invalid code 0x05, then recovery to the same level
        hold(8'h05, 10, 38, ups, first_up, pct_dev);
        chk("fault1_pct_held", pct_dev, 0);
        chk("fault1_input_error", input_error, 1'b1);
        chk("fault1_sticky", error_sticky, 1'b1);
        chk("fault1_count", error_count, 8'd1);
        chk("fault1_valid_kept", level_valid, 1'b1);
        chk("fault1_count_kept", level_count, 4'd3);
        hold(8'h07, 10, 38, ups, first_up, pct_dev);
        chk("recover_input_error", input_error, 1'b0);
        chk("recover_sticky", error_sticky, 1'b1);
        chk("recover_no_update", ups, 0);

        // Second fault, then clear
        hold(8'h0B, 10, 38, ups, first_up, pct_dev);
        chk("fault2_count", error_count, 8'd2);
        chk("fault2_input_error", input_error, 1'b1);
        hold(8'h07, 10, 38, ups, first_up, pct_dev);
        chk("pre_clear_count", error_count, 8'd2);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        chk("clear_sticky", error_sticky, 1'b0);
        chk("clear_count", error_count, 8'd0);

        // Clear coinciding with a fresh fault entry
        sensors_input = 8'h05;
        for (int i = 1; i <= 5; i++) tick();
        chk("coinc_pre_error", input_error, 1'b0);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        chk("coinc_count", error_count, 8'd0);
        chk("coinc_sticky", error_sticky, 1'b1);
        chk("coinc_input_error", input_error, 1'b1);
        hold(8'h05, 4, 38, ups, first_up, pct_dev);
        chk("coinc_no_reincrement", error_count, 8'd0);
        hold(8'h07, 10, 38, ups, first_up, pct_dev);
        chk("coinc_recover", input_error, 1'b0);

        // Reset in the middle of debouncing 0x03
        sensors_input = 8'h03;
        tick();
        tick();
        reset = 1'b1;
        #1;
        chk("async_reset_zero", all_zero(), 1'b1);
        tick();
        reset = 1'b0;
        zero_ok = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            if (level_valid || level_update) zero_ok = 1'b0;
        end
        chk("post_reset_wait", zero_ok, 1'b1);
        tick();
        chk("post_reset_count", level_count, 4'd2);
        chk("post_reset_pct", level_pct, 7'd25);
        chk("post_reset_valid", level_valid, 1'b1);
        chk("post_reset_update", level_update, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
